// File: rtl/snake_pkg.sv
// snake_pkg: shared definitions for the multi-snake direction controller.
//   - DIR_* : 2-bit direction codes (Up 00, Down 01, Left 10, Right 11)
//   - ST_*  : one-hot game state codes, and the state_t enum built on them
//   - is_reverse(a, b) : true when a and b point in opposite directions
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam logic [4:0] ST_I     = 5'b00001;
  localparam logic [4:0] ST_RUN   = 5'b00010;
  localparam logic [4:0] ST_PAUSE = 5'b00100;
  localparam logic [4:0] ST_LOSE  = 5'b01000;
  localparam logic [4:0] ST_WIN   = 5'b10000;

  typedef enum logic [4:0] {
    S_I     = ST_I,
    S_RUN   = ST_RUN,
    S_PAUSE = ST_PAUSE,
    S_LOSE  = ST_LOSE,
    S_WIN   = ST_WIN
  } state_t;

  // Opposite directions share the axis bit (bit 1) and differ in bit 0.
  function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/snake_turn_queue.sv
// snake_turn_queue: QDEPTH-entry FIFO of 2-bit directions for one player.
// Ports:
//   clk, srst      clock and synchronous active-high reset
//   push, din      write din at the tail (accepted when not full, or when a
//                  pop happens in the same cycle)
//   pop            drop the head entry (ignored when empty)
//   flush          empty the queue; overrides push and pop
//   head, tail     oldest and newest stored entries (valid when !empty)
//   count          number of stored entries
//   empty, full    status flags
module snake_turn_queue #(
  parameter int QDEPTH = 2,
  parameter int CW     = $clog2(QDEPTH + 1)
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [1:0]    din,
  output logic [1:0]    head,
  output logic [1:0]    tail,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  logic [1:0]    mem [QDEPTH];
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [PW-1:0] tail_idx;
  logic          do_push;
  logic          do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CW'(QDEPTH));
  assign count    = count_reg;
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push  = push && (!full || do_pop);
  assign tail_idx = (wr_ptr_reg == '0) ? PW'(QDEPTH - 1) : wr_ptr_reg - PW'(1);
  assign head     = mem[rd_ptr_reg];
  assign tail     = mem[tail_idx];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (srst || flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (do_pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      if (do_push && !do_pop) begin
        count_reg <= count_reg + CW'(1);
      end else if (do_pop && !do_push) begin
        count_reg <= count_reg - CW'(1);
      end
    end
  end

endmodule

// File: rtl/snake_multi_dirn_ctrl.sv
// snake_multi_dirn_ctrl: game FSM (I/RUN/PAUSE/LOSE/WIN) and per-player
// direction control for PLAYERS snakes, each with a QDEPTH turn queue.
// Ports:
//   Clk, Reset                 clock, synchronous active-high reset
//   SCEN                       game tick enable
//   Start, Pause, Ack          game control pulses
//   Btn_Valid, In_Dirn         per-player turn requests (2 bits per player)
//   Collide, Full              collision per player / board full, on SCEN
//   Out_Dirn                   registered current direction per player
//   Alive                      players still in the game
//   Drop                       turn rejected because the queue was full
//   q_I..q_Win                 one-hot state flags
module snake_multi_dirn_ctrl
  import snake_pkg::*;
#(
  parameter int         PLAYERS    = 2,
  parameter int         QDEPTH     = 2,
  parameter logic [1:0] START_DIRN = 2'b00
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 SCEN,
  input  logic                 Start,
  input  logic                 Pause,
  input  logic                 Ack,
  input  logic [PLAYERS-1:0]   Btn_Valid,
  input  logic [2*PLAYERS-1:0] In_Dirn,
  input  logic [PLAYERS-1:0]   Collide,
  input  logic                 Full,
  output logic [2*PLAYERS-1:0] Out_Dirn,
  output logic [PLAYERS-1:0]   Alive,
  output logic [PLAYERS-1:0]   Drop,
  output logic                 q_I,
  output logic                 q_Run,
  output logic                 q_Pause,
  output logic                 q_Lose,
  output logic                 q_Win
);

  localparam int QCW = $clog2(QDEPTH + 1);

  state_t                   state_reg;
  logic [2*PLAYERS-1:0]     dirn_reg;
  logic [PLAYERS-1:0]       alive_reg;
  logic [PLAYERS-1:0]       drop_reg;

  logic                     run_tick;
  logic                     reload;
  logic [PLAYERS-1:0]       alive_next;
  logic [PLAYERS-1:0]       q_push;
  logic [PLAYERS-1:0]       q_pop;
  logic [PLAYERS-1:0]       q_flush;
  logic [PLAYERS-1:0]       q_empty;
  logic [PLAYERS-1:0]       q_full;
  logic [PLAYERS-1:0]       reject;
  logic [2*PLAYERS-1:0]     head_all;
  logic [2*PLAYERS-1:0]     tail_all;
  logic [PLAYERS*QCW-1:0]   count_all;

  assign run_tick   = (state_reg == S_RUN) && SCEN;
  // Entering a new game (Start) or leaving an ended one (Ack) resets players.
  assign reload     = ((state_reg == S_I) && Start) ||
                      (((state_reg == S_LOSE) || (state_reg == S_WIN)) && Ack);
  assign alive_next = alive_reg & ~Collide;

  generate
    for (genvar gi = 0; gi < PLAYERS; gi++) begin : g_player
      logic [1:0] req_dirn;
      logic [1:0] ref_dirn;
      logic       want;

      assign req_dirn = In_Dirn[2*gi +: 2];
      // Compare against the last queued turn so a rapid sequence is
      // validated as the path the snake will actually take.
      assign ref_dirn = q_empty[gi] ? dirn_reg[2*gi +: 2] : tail_all[2*gi +: 2];
      assign want     = (state_reg == S_RUN) && alive_reg[gi] && Btn_Valid[gi] &&
                        (req_dirn != ref_dirn) && !is_reverse(req_dirn, ref_dirn);

      assign q_pop[gi]   = run_tick && alive_reg[gi] &&
                           (count_all[gi*QCW +: QCW] != '0);
      assign q_push[gi]  = want;
      assign reject[gi]  = want && q_full[gi] && !q_pop[gi];
      // A player dying on this tick loses its pending turns.
      assign q_flush[gi] = reload || (run_tick && !alive_next[gi]);

      snake_turn_queue #(
        .QDEPTH (QDEPTH),
        .CW     (QCW)
      ) u_queue (
        .clk    (Clk),
        .srst   (Reset),
        .push   (q_push[gi]),
        .pop    (q_pop[gi]),
        .flush  (q_flush[gi]),
        .din    (req_dirn),
        .head   (head_all[2*gi +: 2]),
        .tail   (tail_all[2*gi +: 2]),
        .count  (count_all[gi*QCW +: QCW]),
        .empty  (q_empty[gi]),
        .full   (q_full[gi])
      );
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= S_I;
      dirn_reg  <= {PLAYERS{START_DIRN}};
      alive_reg <= '1;
      drop_reg  <= '0;
    end else begin
      drop_reg <= reject;
      case (state_reg)
        S_I: begin
          if (Start) begin
            state_reg <= S_RUN;
            dirn_reg  <= {PLAYERS{START_DIRN}};
            alive_reg <= '1;
          end
        end
        S_RUN: begin
          if (SCEN) begin
            for (int p = 0; p < PLAYERS; p++) begin
              if (q_pop[p]) begin
                dirn_reg[2*p +: 2] <= head_all[2*p +: 2];
              end
            end
            alive_reg <= alive_next;
            // End-of-game outcomes take precedence over a coincident Pause.
            if (alive_next == '0) begin
              state_reg <= S_LOSE;
            end else if (Full) begin
              state_reg <= S_WIN;
            end else if (Pause) begin
              state_reg <= S_PAUSE;
            end
          end else if (Pause) begin
            state_reg <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (Pause) begin
            state_reg <= S_RUN;
          end
        end
        S_LOSE, S_WIN: begin
          if (Ack) begin
            state_reg <= S_I;
            dirn_reg  <= {PLAYERS{START_DIRN}};
            alive_reg <= '1;
          end
        end
        default: begin
          state_reg <= S_I;
        end
      endcase
    end
  end

  assign Out_Dirn = dirn_reg;
  assign Alive    = alive_reg;
  assign Drop     = drop_reg;
  assign q_I      = (state_reg == S_I);
  assign q_Run    = (state_reg == S_RUN);
  assign q_Pause  = (state_reg == S_PAUSE);
  assign q_Lose   = (state_reg == S_LOSE);
  assign q_Win    = (state_reg == S_WIN);

endmodule
